// File: rtl/angle_reducer.sv
// Reduces an unsigned degree angle to a quadrant and a 0..90 reference angle
// by repeated subtraction of 360. Results are held until the next done pulse.
module angle_reducer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] angle_in,
  output logic                  busy,
  output logic                  done,
  output logic                  en_secant,
  output logic [1:0]            quadrant,
  output logic [DATA_WIDTH-1:0] angle_out
);

  localparam logic [DATA_WIDTH-1:0] DEG_90  = DATA_WIDTH'(90);
  localparam logic [DATA_WIDTH-1:0] DEG_180 = DATA_WIDTH'(180);
  localparam logic [DATA_WIDTH-1:0] DEG_270 = DATA_WIDTH'(270);
  localparam logic [DATA_WIDTH-1:0] DEG_360 = DATA_WIDTH'(360);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  done_d;
  logic [1:0]            quad_d;
  logic [DATA_WIDTH-1:0] out_d;

  // State, working register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      en_secant <= 1'b0;
      quadrant  <= 2'd0;
      angle_out <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      busy      <= (state_d != IDLE);
      done      <= done_d;
      en_secant <= done_d;
      if (done_d) begin
        quadrant  <= quad_d;
        angle_out <= out_d;
      end
    end
  end

  // Next state and working-register update
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = angle_in;
          state_d = MOD;
        end
      end
      MOD: begin
        if (r_q >= DEG_360) begin
          r_d = r_q - DEG_360;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Quadrant / reference-angle mapping of the reduced angle and done strobe
  always_comb begin
    done_d = (state_q == MOD) && (r_q < DEG_360);
    quad_d = 2'd0;
    out_d  = r_q;
    if (r_q < DEG_90) begin
      quad_d = 2'd0;
      out_d  = r_q;
    end else if (r_q < DEG_180) begin
      quad_d = 2'd1;
      out_d  = DEG_180 - r_q;
    end else if (r_q < DEG_270) begin
      quad_d = 2'd2;
      out_d  = r_q - DEG_180;
    end else begin
      quad_d = 2'd3;
      out_d  = DEG_360 - r_q;
    end
  end

endmodule

// File: tb/tb_angle_reducer.sv
// Directed and table-driven checks for angle_reducer.
module tb_angle_reducer;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] angle_in;
  logic         busy;
  logic         done;
  logic         en_secant;
  logic [1:0]   quadrant;
  logic [W-1:0] angle_out;

  int checks;
  int errors;

  angle_reducer #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .angle_in  (angle_in),
    .busy      (busy),
    .done      (done),
    .en_secant (en_secant),
    .quadrant  (quadrant),
    .angle_out (angle_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned angle;
    int unsigned q;
    int unsigned out;
    int unsigned lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference mapping built on the modulo operator
  task automatic ref_map(input int unsigned a, output int unsigned q, output int unsigned o);
    int unsigned m;
    m = a % 360;
    if (m < 90)       begin q = 0; o = m;       end
    else if (m < 180) begin q = 1; o = 180 - m; end
    else if (m < 270) begin q = 2; o = m - 180; end
    else              begin q = 3; o = 360 - m; end
  endtask

  // One full operation: capture, wait for done (bounded), check result and hold
  task automatic run_op(input int unsigned a, input int unsigned eq, input int unsigned eo,
                        input int unsigned el, input string tag);
    int unsigned lat;
    bit          seen;
    @(negedge clk);
    start    = 1'b1;
    angle_in = W'(a);
    @(posedge clk);
    #1;
    start    = 1'b0;
    angle_in = W'(32'hDEAD_BEEF);
    check({tag, " busy_after_capture"}, busy, 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, lat, el);
    check({tag, " quadrant"}, quadrant, eq);
    check({tag, " angle_out"}, angle_out, eo);
    check({tag, " en_secant"}, en_secant, 1);
    check({tag, " busy_in_done"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, " done_cleared"}, done, 0);
    check({tag, " busy_cleared"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, " quadrant_hold"}, quadrant, eq);
    check({tag, " angle_out_hold"}, angle_out, eo);
  endtask

  initial begin
    int unsigned rq;
    int unsigned ro;
    int unsigned ra;
    bit          done_in_reset;

    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    angle_in = '0;

    vecs[0]  = '{45,   0, 45, 1};
    vecs[1]  = '{135,  1, 45, 1};
    vecs[2]  = '{200,  2, 20, 1};
    vecs[3]  = '{300,  3, 60, 1};
    vecs[4]  = '{750,  0, 30, 3};
    vecs[5]  = '{360,  0, 0,  2};
    vecs[6]  = '{0,    0, 0,  1};
    vecs[7]  = '{89,   0, 89, 1};
    vecs[8]  = '{90,   1, 90, 1};
    vecs[9]  = '{179,  1, 1,  1};
    vecs[10] = '{180,  2, 0,  1};
    vecs[11] = '{269,  2, 89, 1};
    vecs[12] = '{359,  3, 1,  1};
    vecs[13] = '{719,  3, 1,  2};
    vecs[14] = '{1000, 3, 80, 3};
    vecs[15] = '{270,  3, 90, 1};

    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quadrant", quadrant, 0);
    check("reset_angle_out", angle_out, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].angle, vecs[i].q, vecs[i].out, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Asynchronous reset during a long reduction (last result was q=3, out=90)
    @(negedge clk);
    start    = 1'b1;
    angle_in = W'(3600);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_en_secant", en_secant, 0);
    check("async_quadrant", quadrant, 0);
    check("async_angle_out", angle_out, 0);
    done_in_reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) done_in_reset = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) done_in_reset = 1'b1;
    end
    check("abort_no_done", done_in_reset, 0);
    run_op(90, 1, 90, 1, "after_reset");

    // start held high: one done every third cycle, angle_in changes ignored
    @(negedge clk);
    start    = 1'b1;
    angle_in = W'(100);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stream_done_c%0d", i), done, (i % 3 == 2) ? 1 : 0);
      check($sformatf("stream_en_c%0d", i), en_secant, (i % 3 == 2) ? 1 : 0);
      if (i % 3 == 2) begin
        check($sformatf("stream_q_c%0d", i), quadrant, 1);
        check($sformatf("stream_out_c%0d", i), angle_out, 80);
      end
      if (i % 3 == 0) angle_in = W'(100);
      else            angle_in = W'(7 + i * 50);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);

    // Random sweep against modulo reference
    for (int n = 0; n < 20; n++) begin
      ra = $urandom_range(100000, 0);
      ref_map(ra, rq, ro);
      run_op(ra, rq, ro, ra / 360 + 1, $sformatf("rand%0d_%0d", n, ra));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
